// File: rtl/lab1_qsys_pio_led_chaser_if.sv
// Avalon-MM slave bus bundle for the LED chaser PIO (2-bit address, 32-bit data, read latency 1).
interface lab1_qsys_pio_led_chaser_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab1_qsys_pio_led_chaser.sv
// Output PIO holding a CPU-written LED pattern, with an optional hardware chaser that
// rotates (or bounces) the pattern every max(PERIOD,1) clocks.
module lab1_qsys_pio_led_chaser #(
  parameter int unsigned      WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE    = WIDTH'(8'h01),
  parameter logic [31:0]      PERIOD_DEFAULT = 32'd5000000
) (
  input  logic                          clk,
  input  logic                          reset,
  lab1_qsys_pio_led_chaser_if.slave     bus,
  output logic [WIDTH-1:0]              out_port,
  output logic                          tick
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_CONTROL = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic [WIDTH-1:0] data_q,   data_d;
  logic             auto_q,   auto_d;
  logic             dir_q,    dir_d;
  logic             bounce_q, bounce_d;
  logic [DW-1:0]    period_q, period_d;
  logic [DW-1:0]    cnt_q,    cnt_d;
  logic             step_q,   step_d;
  logic             tick_q,   tick_d;
  logic [DW-1:0]    rdata_q,  rdata_d;

  logic             wr_c;
  logic             step_c;
  logic             go_right_c;
  logic             dir_step_c;
  logic [DW-1:0]    period_m1_c;

  function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) r[(i + 1) % WIDTH] = d[i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) r[i] = d[(i + 1) % WIDTH];
    return r;
  endfunction

  // Next-state logic: chaser step first, then bus writes override it.
  always_comb begin
    data_d      = data_q;
    auto_d      = auto_q;
    dir_d       = dir_q;
    bounce_d    = bounce_q;
    period_d    = period_q;
    cnt_d       = auto_q ? cnt_q + DW'(1) : '0;
    step_d      = step_q;
    tick_d      = 1'b0;
    rdata_d     = '0;
    go_right_c  = dir_q;
    dir_step_c  = dir_q;

    wr_c        = bus.chipselect & ~bus.write_n;
    period_m1_c = (period_q == '0) ? '0 : period_q - DW'(1);
    step_c      = auto_q && (cnt_q == period_m1_c) && !(wr_c && bus.address == ADDR_DATA);

    // Bounce reverses at the ends of the pattern before rotating.
    if (bounce_q && !dir_q && data_q[WIDTH-1]) begin
      go_right_c = 1'b1;
      dir_step_c = 1'b1;
    end else if (bounce_q && dir_q && data_q[0]) begin
      go_right_c = 1'b0;
      dir_step_c = 1'b0;
    end

    if (step_c) begin
      data_d = go_right_c ? rot_right(data_q) : rot_left(data_q);
      dir_d  = dir_step_c;
      cnt_d  = '0;
      tick_d = 1'b1;
    end

    if (wr_c) begin
      case (bus.address)
        ADDR_DATA: begin
          data_d = bus.writedata[WIDTH-1:0];
          cnt_d  = '0;
        end
        ADDR_CONTROL: begin
          auto_d   = bus.writedata[0];
          dir_d    = bus.writedata[1];
          bounce_d = bus.writedata[2];
          if (bus.writedata[0] != auto_q) cnt_d = '0;
        end
        ADDR_PERIOD: begin
          period_d = bus.writedata;
          cnt_d    = '0;
        end
        default: begin
          if (bus.writedata[0]) step_d = 1'b0;
        end
      endcase
    end

    if (step_c) step_d = 1'b1;

    case (bus.address)
      ADDR_DATA:    rdata_d = DW'(data_q);
      ADDR_CONTROL: rdata_d = DW'({bounce_q, dir_q, auto_q});
      ADDR_PERIOD:  rdata_d = period_q;
      default:      rdata_d = DW'(step_q);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      auto_q   <= 1'b0;
      dir_q    <= 1'b0;
      bounce_q <= 1'b0;
      period_q <= PERIOD_DEFAULT;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      tick_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      data_q   <= data_d;
      auto_q   <= auto_d;
      dir_q    <= dir_d;
      bounce_q <= bounce_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      rdata_q  <= rdata_d;
    end
  end

  assign out_port     = data_q;
  assign tick         = tick_q;
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_lab1_qsys_pio_led_chaser.sv
// Directed bench for the LED chaser PIO: bus writes/reads, stepping, bounce, collisions, reset.
module tb_lab1_qsys_pio_led_chaser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] out_port;
  logic       tick;
  int         n_cmp = 0;
  int         n_mis = 0;

  lab1_qsys_pio_led_chaser_if bus ();

  lab1_qsys_pio_led_chaser #(
    .WIDTH(8), .RESET_VALUE(8'h01), .PERIOD_DEFAULT(32'd5000000)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .out_port(out_port), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          nt;
    logic [7:0]  bexp [9];
    bexp = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    reset          = 1'b1;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;

    // Reset state
    cyc(3);
    chk("rst_out", 32'(out_port), 32'h01);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_rdata", bus.readdata, 32'h0);
    reset = 1'b0;
    bus_read(2'd1, rd);  chk("rst_control", rd, 32'h0);
    bus_read(2'd2, rd);  chk("rst_period", rd, 32'h004C4B40);
    bus_read(2'd3, rd);  chk("rst_status", rd, 32'h0);

    // Manual drive, no chaser
    bus_write(2'd0, 32'hA5);
    chk("data_wr_out", 32'(out_port), 32'hA5);
    bus_read(2'd0, rd);  chk("data_rd", rd, 32'hA5);
    nt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("auto0_no_tick", 32'(nt), 32'h0);

    // Rotate left, period 4
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h81);
    bus_write(2'd1, 32'h1);
    cyc(3);  chk("rl_pre_out", 32'(out_port), 32'h81);  chk("rl_pre_tick", 32'(tick), 32'h0);
    cyc(1);  chk("rl_s1_out", 32'(out_port), 32'h03);   chk("rl_s1_tick", 32'(tick), 32'h1);
    cyc(1);  chk("rl_s1_tick_off", 32'(tick), 32'h0);
    cyc(3);  chk("rl_s2_out", 32'(out_port), 32'h06);   chk("rl_s2_tick", 32'(tick), 32'h1);
    cyc(4);  chk("rl_s3_out", 32'(out_port), 32'h0C);
    bus_write(2'd1, 32'h0);
    bus_read(2'd3, rd);  chk("status_set", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);  chk("status_clr", rd, 32'h0);
    chk("stopped_out", 32'(out_port), 32'h0C);

    // Rotate right wrap
    bus_write(2'd0, 32'h01);
    bus_write(2'd1, 32'h3);
    cyc(3);  chk("rr_pre_out", 32'(out_port), 32'h01);
    cyc(1);  chk("rr_wrap_out", 32'(out_port), 32'h80); chk("rr_wrap_tick", 32'(tick), 32'h1);

    // Bounce, period 2
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h40);
    bus_write(2'd1, 32'h5);
    bus.address = 2'd1;
    for (int i = 0; i < 9; i++) begin
      cyc(2);
      chk($sformatf("bounce_%0d", i), 32'(out_port), 32'(bexp[i]));
      if (i == 2) chk("bounce_dir_right", bus.readdata, 32'h7);
    end
    cyc(1);  chk("bounce_dir_left", bus.readdata, 32'h5);

    // Collisions: DATA write in the step cycle, then STATUS clear in a step cycle
    bus_write(2'd1, 32'h0);
    bus_write(2'd2, 32'd4);
    bus_write(2'd0, 32'h01);
    bus_write(2'd1, 32'h1);
    cyc(2);
    bus_write(2'd0, 32'h55);
    chk("col_data_out", 32'(out_port), 32'h55);
    chk("col_data_tick", 32'(tick), 32'h0);
    cyc(3);  chk("col_hold_out", 32'(out_port), 32'h55); chk("col_hold_tick", 32'(tick), 32'h0);
    cyc(1);  chk("col_next_out", 32'(out_port), 32'hAA); chk("col_next_tick", 32'(tick), 32'h1);
    cyc(2);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rd);  chk("col_status_setwins", rd, 32'h1);

    // Asynchronous reset mid-run
    bus_write(2'd1, 32'h0);
    bus_write(2'd0, 32'h08);
    bus_write(2'd2, 32'd4);
    bus_write(2'd1, 32'h1);
    cyc(4);  chk("mid_out", 32'(out_port), 32'h10);
    cyc(1);
    #2 reset = 1'b1;
    #1;
    chk("arst_out", 32'(out_port), 32'h01);
    chk("arst_tick", 32'(tick), 32'h0);
    chk("arst_rdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    nt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("post_rst_no_tick", 32'(nt), 32'h0);
    chk("post_rst_out", 32'(out_port), 32'h01);
    bus_read(2'd1, rd);  chk("post_rst_control", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
